arith_shift_seq: RTL and testbench



---
 rtl/arith_shift_seq.sv | 132 +++++++++++++
 tb/tb_arith_shift_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/arith_shift_seq.sv
// Sequential arithmetic left shifter: one 1-bit shift per clock over valid/ready handshakes.
// Optional sticky signed-overflow tracking is compiled in with `define ARITH_SHIFT_OVF_EN.
module arith_shift_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, out_valid_q, busy_q;

    // Next-state, operand and count computation.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = in_shamt;
                    state_d = (in_shamt != CNT_ZERO) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_d = {data_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and handshake flags; flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            data_q      <= {WIDTH{1'b0}};
            cnt_q       <= CNT_ZERO;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

`ifdef ARITH_SHIFT_OVF_EN
    logic ovf_q, ovf_d;

    // Overflow is sticky: any step whose two top bits differ flips the sign.
    always_comb begin
        ovf_d = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ovf_d = 1'b0;
                end else begin
                    ovf_d = ovf_q;
                end
            end
            ST_SHIFT: begin
                ovf_d = ovf_q | (data_q[WIDTH-1] ^ data_q[WIDTH-2]);
            end
            default: begin
                ovf_d = ovf_q;
            end
        endcase
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_arith_shift_seq.sv
// Self-checking bench for arith_shift_seq: directed test-plan cases plus random operations
// compared against an arithmetic reference model (d * 2^n, signed range check).
module tb_arith_shift_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [2:0] in_shamt;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_ovf;
    logic       busy;

    int total;
    int bad;

    arith_shift_seq #(.WIDTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_data(input logic [3:0] d, input int n);
        int v;
        v = int'(d) * (1 << n);
        return v[3:0];
    endfunction

    // Overflow happened iff the exact signed product leaves the 4-bit signed range.
    function automatic logic ref_ovf(input logic [3:0] d, input int n);
        int v;
`ifdef ARITH_SHIFT_OVF_EN
        v = int'($signed(d)) * (1 << n);
        return (v > 7) || (v < -8);
`else
        v = 0;
        return (d === 4'bxxxx) && (v != 0);
`endif
    endfunction

    task automatic run_op(input string tag, input logic [3:0] d, input int n, input int stall);
        int k;
        logic [3:0] hold_d;
        logic hold_o;
        chk({tag, ".in_ready_pre"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = n[2:0];
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
        in_shamt = 3'($urandom_range(0, 7));
        k = 1;
        while (!out_valid && k < 20) begin
            chk({tag, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            k++;
        end
        chk({tag, ".latency"}, k, n + 1);
        chk({tag, ".data"}, {28'd0, out_data}, {28'd0, ref_data(d, n)});
        chk({tag, ".ovf"}, {31'd0, out_ovf}, {31'd0, ref_ovf(d, n)});
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        hold_d = out_data;
        hold_o = out_ovf;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_data  = 4'($urandom_range(0, 15));
            in_shamt = 3'd0;
            @(negedge clk);
            chk({tag, ".stall_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, ".stall_ready"}, {31'd0, in_ready}, 32'd0);
            chk({tag, ".stall_data"}, {28'd0, out_data}, {28'd0, hold_d});
            chk({tag, ".stall_ovf"}, {31'd0, out_ovf}, {31'd0, hold_o});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".post_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".post_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".post_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 4'd0;
        in_shamt = 3'd0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset.out_data", {28'd0, out_data}, 32'd0);
        chk("reset.out_ovf", {31'd0, out_ovf}, 32'd0);
        chk("reset.busy", {31'd0, busy}, 32'd0);

        run_op("tp_0011_1", 4'b0011, 1, 0);
        run_op("tp_0101_2", 4'b0101, 2, 0);
        run_op("tp_1001_0", 4'b1001, 0, 0);
        run_op("tp_1111_7", 4'b1111, 7, 0);
        run_op("tp_bp", 4'b0110, 3, 5);

        // Reset in the middle of a shift discards the operation.
        chk("rst.pre_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = 4'b0111;
        in_shamt = 3'd6;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.out_data", {28'd0, out_data}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst.no_result", {31'd0, out_valid}, 32'd0);
        end
        run_op("rst_next", 4'b0001, 2, 0);

        for (int i = 0; i < 24; i++) begin
            run_op("rand", 4'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
